// File: rtl/sa_act_skew_feeder_if.sv
// Activation feeder bus: upstream vector handshake plus the skewed lane
// outputs that drive the left edge of the systolic array.
//   in_valid/in_ready/in_data/in_last : upstream vector handshake
//   out_data/out_valid                : per-lane skewed activation and tag
//   done                              : last vector's final lane is on out_data
// master = upstream/array side, slave = feeder side.
interface sa_act_skew_feeder_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   in_data;
  logic                  in_last;
  logic [N*DATA_W-1:0]   out_data;
  logic [N-1:0]          out_valid;
  logic                  done;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_data, out_valid, done
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_data, out_valid, done
  );
endinterface

// File: rtl/sa_act_skew_feeder.sv
// Left-edge activation feeder for the systolic array. Buffers incoming
// N-lane vectors in a DEPTH-entry FIFO and emits them diagonally skewed:
// lane i is delayed i cycles behind lane 0. Zero bubbles are injected
// whenever run is low or the FIFO is empty; the skew chains never stall.
// Ports:
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset
//   clear : synchronous flush of FIFO and skew pipeline (highest priority)
//   run   : lets the FIFO head enter the skew pipeline this cycle
//   busy  : FIFO non-empty or any skew stage holds a valid word
//   bus   : vector handshake and skewed lane outputs (slave modport)
module sa_act_skew_feeder #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   run,
  output logic                   busy,
  sa_act_skew_feeder_if.slave    bus
);

  localparam int unsigned VW = N * DATA_W;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // FIFO entry = {last, data}
  logic [VW:0]    mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [VW:0]    head;
  logic           full, push, pop;

  logic [VW-1:0]  s0_data_q;
  logic           s0_v_q, s0_last_q;
  logic [N-2:0]   last_q;

  logic [DATA_W-1:0] tap_data [N];
  logic [N-1:0]      tap_v;
  logic [N-1:0]      lane_any;

  assign full         = (count_q == DEPTH_C);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full && !clear;
  assign pop          = run && (count_q != '0) && !clear;
  assign head         = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else if (clear) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.in_last, bus.in_data};
  end

  // Stage 0 loads a bubble whenever no pop happens; clear suppresses pop,
  // so it also zeroes this stage without a separate branch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_data_q <= '0;
      s0_v_q    <= 1'b0;
      s0_last_q <= 1'b0;
    end else begin
      s0_data_q <= pop ? head[VW-1:0] : '0;
      s0_v_q    <= pop;
      s0_last_q <= pop && head[VW];
    end
  end

  // last only matters where done is decoded, so it rides the lane N-1 chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= '0;
    end else if (clear) begin
      last_q <= '0;
    end else begin
      last_q[0] <= s0_last_q;
      for (int unsigned k = 1; k < N - 1; k++) last_q[k] <= last_q[k-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign tap_data[0] = s0_data_q[DATA_W-1:0];
      assign tap_v[0]    = s0_v_q;
      assign lane_any[0] = s0_v_q;
    end else begin : g_chain
      logic [DATA_W-1:0] d_q [i];
      logic [i-1:0]      v_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int unsigned k = 0; k < i; k++) d_q[k] <= '0;
          v_q <= '0;
        end else if (clear) begin
          for (int unsigned k = 0; k < i; k++) d_q[k] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= s0_data_q[i*DATA_W +: DATA_W];
          v_q[0] <= s0_v_q;
          for (int unsigned k = 1; k < i; k++) begin
            d_q[k] <= d_q[k-1];
            v_q[k] <= v_q[k-1];
          end
        end
      end

      assign tap_data[i] = d_q[i-1];
      assign tap_v[i]    = v_q[i-1];
      assign lane_any[i] = |v_q;
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned i = 0; i < N; i++) bus.out_data[i*DATA_W +: DATA_W] = tap_data[i];
  end

  assign bus.out_valid = tap_v;
  assign bus.done      = tap_v[N-1] && last_q[N-2];
  assign busy          = (count_q != '0) || (|lane_any);

endmodule

// File: tb/tb_sa_act_skew_feeder.sv
module tb_sa_act_skew_feeder;
  localparam int unsigned N     = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned VW    = N * W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  logic run = 1'b0;
  logic busy;

  sa_act_skew_feeder_if #(.N(N), .DATA_W(W)) bus ();

  sa_act_skew_feeder #(.N(N), .DATA_W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .run   (run),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  bit cmp_en = 1'b0;

  // Reference: FIFO as a queue, plus a timeline of what entered stage 0 on
  // each of the last N edges. Lane i shows what entered stage 0 i edges ago.
  logic [VW:0]   mq [$];
  logic [VW-1:0] h_data [N];
  logic          h_v    [N];
  logic          h_last [N];

  task automatic model_flush();
    mq.delete();
    for (int i = 0; i < N; i++) begin
      h_data[i] = '0;
      h_v[i]    = 1'b0;
      h_last[i] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn || clear) begin
      model_flush();
    end else begin : m_step
      bit          do_push, do_pop;
      logic [VW:0] hd;
      do_push = bus.in_valid && (mq.size() != DEPTH);
      do_pop  = run && (mq.size() != 0);
      for (int k = N - 1; k > 0; k--) begin
        h_data[k] = h_data[k-1];
        h_v[k]    = h_v[k-1];
        h_last[k] = h_last[k-1];
      end
      if (do_pop) begin
        hd = mq.pop_front();
        h_data[0] = hd[VW-1:0];
        h_v[0]    = 1'b1;
        h_last[0] = hd[VW];
      end else begin
        h_data[0] = '0;
        h_v[0]    = 1'b0;
        h_last[0] = 1'b0;
      end
      if (do_push) mq.push_back({bus.in_last, bus.in_data});
    end
  end

  function automatic logic [VW-1:0] exp_data();
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = h_data[i][i*W +: W];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = h_v[i];
    return r;
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = (mq.size() != 0);
    for (int i = 0; i < N; i++) b = b | h_v[i];
    return b;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_data",  bus.out_data,  exp_data());
      chk("out_valid", VW'(bus.out_valid), VW'(exp_valid()));
      chk("done",      VW'(bus.done),  VW'(h_v[N-1] && h_last[N-1]));
      chk("busy",      VW'(busy),      VW'(exp_busy()));
      chk("in_ready",  VW'(bus.in_ready), VW'(mq.size() != DEPTH));
      if (bus.done === 1'b1) done_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic push_vec(input logic [VW-1:0] d, input logic l);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int c = 0; c < 50 && !acc; c++) begin
      acc = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("push_accepted", VW'(acc), VW'(1));
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  task automatic single_test(input string tag);
    logic [VW-1:0] v;
    v = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    done_seen = 0;
    run = 1'b1;
    push_vec(v, 1'b1);                 // edge 0
    step();                            // edge 1
    chk({tag, "_l0_data"},  VW'(bus.out_data[31:0]), VW'(32'h3F800000));
    chk({tag, "_l0_valid"}, VW'(bus.out_valid), VW'(4'b0001));
    step();                            // edge 2
    chk({tag, "_l1_data"},  VW'(bus.out_data[63:32]), VW'(32'h40000000));
    chk({tag, "_l0_zero"},  VW'(bus.out_data[31:0]), VW'(0));
    step();                            // edge 3
    chk({tag, "_l2_data"},  VW'(bus.out_data[95:64]), VW'(32'h40400000));
    step();                            // edge 4
    chk({tag, "_l3_data"},  VW'(bus.out_data[127:96]), VW'(32'h40800000));
    chk({tag, "_l3_valid"}, VW'(bus.out_valid), VW'(4'b1000));
    chk({tag, "_low_zero"}, VW'(bus.out_data[95:0]), VW'(0));
    chk({tag, "_done"},     VW'(bus.done), VW'(1));
    step();                            // edge 5
    chk({tag, "_busy_low"}, VW'(busy), VW'(0));
    chk({tag, "_done_cnt"}, VW'(done_seen), VW'(1));
  endtask

  initial begin
    model_flush();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_valid", VW'(bus.out_valid), VW'(0));
    chk("rst_data",  bus.out_data, '0);
    chk("rst_busy",  VW'(busy), VW'(0));
    chk("rst_ready", VW'(bus.in_ready), VW'(1));
    rstn = 1'b1;
    step();

    single_test("single");

    // Streaming: 8 back-to-back vectors, only the last one tagged
    done_seen = 0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("stream_ready", VW'(bus.in_ready), VW'(1));
      push_vec(rand_vec(), i == 7);
    end
    idle(8);
    chk("stream_done_cnt", VW'(done_seen), VW'(1));

    // Backpressure: fill with run low, fifth waits for the first pop
    done_seen = 0;
    run = 1'b0;
    for (int i = 0; i < 4; i++) push_vec(rand_vec(), 1'b0);
    chk("bp_full_ready", VW'(bus.in_ready), VW'(0));
    run = 1'b1;
    push_vec(rand_vec(), 1'b1);
    idle(10);
    chk("bp_done_cnt", VW'(done_seen), VW'(1));

    // Run gap mid-stream
    for (int i = 0; i < 6; i++) begin
      run = (i != 3);
      push_vec(rand_vec(), i == 5);
    end
    run = 1'b1;
    idle(8);

    // Clear with 3 queued and the tagged vector still in flight
    done_seen = 0;
    run = 1'b1;
    push_vec(rand_vec(), 1'b0);
    push_vec(rand_vec(), 1'b1);
    push_vec(rand_vec(), 1'b0);
    run = 1'b0;
    push_vec(rand_vec(), 1'b0);
    push_vec(rand_vec(), 1'b0);
    chk("clr_busy_before", VW'(busy), VW'(1));
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_valid", VW'(bus.out_valid), VW'(0));
    chk("clr_busy",  VW'(busy), VW'(0));
    chk("clr_ready", VW'(bus.in_ready), VW'(1));
    run = 1'b1;
    idle(6);
    chk("clr_done_cnt", VW'(done_seen), VW'(0));

    // Async reset between edges mid-stream
    run = 1'b1;
    for (int i = 0; i < 3; i++) push_vec(rand_vec(), 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_data",  bus.out_data, '0);
    chk("arst_valid", VW'(bus.out_valid), VW'(0));
    chk("arst_done",  VW'(bus.done), VW'(0));
    chk("arst_busy",  VW'(busy), VW'(0));
    @(negedge clk);
    rstn = 1'b1;
    step();
    single_test("post_rst");

    // Randomized traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      run          = ($urandom_range(0, 3) != 0);
      clear        = ($urandom_range(0, 39) == 0);
      bus.in_valid = ($urandom_range(0, 9) < 6) && !clear;
      bus.in_data  = rand_vec();
      bus.in_last  = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.in_valid = 1'b0;
    clear = 1'b0;
    run = 1'b1;
    idle(12);
    chk("final_idle_busy", VW'(busy), VW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
